uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares the single FastUART transmitter between several byte-stream requesters (RV32I cores, the Wishbone debug path, test logic). Each requester presents bytes with a valid/ready handshake and marks the final byte of a message with `last`. The grant is held until that byte has been sent, so messages such as the "Hello" banner never interleave. The arbiter sits between the requesters and FastUART's `txEnable`/`txData`/`txBusy` port.

## Interface
- `REQUESTERS`, 4: number of requesters; legal range 2–8.
- `TIMEOUT_CYCLES`, 1024: stall limit for an in-packet lock; used only with `UART_TX_ARB_TIMEOUT_EN`; legal range ≥ 2.
- `GW` (localparam) = clog2(`REQUESTERS`).

- `clk`  in  1  system clock, 40 MHz nominal.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `REQUESTERS`  per-requester byte valid.
- `req_data`  in  8*`REQUESTERS`  byte for requester i at bits [8i+7:8i].
- `req_last`  in  `REQUESTERS`  byte is the final byte of the message.
- `req_ready`  out  `REQUESTERS`  one-hot byte-accept strobe.
- `uart_txEnable`  out  1  one-cycle start pulse to FastUART.
- `uart_txData`  out  8  byte to FastUART; stable while FastUART is busy.
- `uart_txBusy`  in  1  FastUART transmitter busy.
- `grant_id`  out  `GW`  index of the current or last owner.
- `grant_active`  out  1  a requester holds the lock.
- `timeout_event`  out  1  one-cycle pulse when a lock is force-released.

## Operation
- **States:** IDLE, ARB, ACCEPT, SEND, HOLD, DRAIN.
- **IDLE:** no lock.
  - When any `req_valid` is set, go to ARB.
- **ARB:** one cycle.
  - Pick the first requester with `req_valid` set, searching from `rr_ptr`+1 and wrapping modulo `REQUESTERS`.
  - Load `grant_id`, set `grant_active`, set `rr_ptr`=`grant_id`, then go to ACCEPT.
- **ACCEPT:**
  - If `req_valid[grant_id]` is set and `uart_txBusy` is clear, pulse `req_ready[grant_id]` for one cycle.
  - On that pulse, capture `req_data` into `uart_txData`, capture `req_last` into `last_q`, and go to SEND.
  - Otherwise stay in ACCEPT. The lock is kept even while `req_valid` is low.
- **SEND:** pulse `uart_txEnable` for one cycle, then go to HOLD.
- **HOLD:** one-cycle guard that covers FastUART's one-cycle busy-assertion delay, then go to DRAIN.
- **DRAIN:** wait until `uart_txBusy` is clear.
  - If `last_q` is set: clear `grant_active` and go to IDLE.
  - If `last_q` is clear: go to ACCEPT.
- **Grant priority:** a non-owner never receives `req_ready`, and only the owner's `req_ready` bit can be set.
- **Round-robin order:** after reset `rr_ptr` = `REQUESTERS`-1, so requester 0 has first priority.
- **Simultaneous requests:** requests from 0 and 2 with `rr_ptr`=0 grant 2 first; requests from 0 and 2 with `rr_ptr`=2 grant 0 first.
- **Owner rearming while others wait:** if the owner drops its lock and immediately raises `req_valid` again while others are waiting, the others are served first.
- **One-byte message:** a byte with `req_last`=1 accepted as the first byte is a complete message and is legal.
- **Reset mid-operation:** the state machine is forced to IDLE immediately.
  - `uart_txEnable` and `req_ready` drop asynchronously.
  - A byte already inside FastUART completes on the wire; the arbiter ignores it.

## Timing
- **Reset values:** `req_ready`=0, `uart_txEnable`=0, `uart_txData`=8'h00, `grant_id`=`REQUESTERS`-1, `grant_active`=0, `timeout_event`=0.
- **First byte latency:** `req_valid` rising in IDLE with `uart_txBusy`=0 gives:
  - ARB at +1;
  - `req_ready` at +2;
  - `uart_txEnable` at +3.
- **Back-to-back bytes within a packet:**
  - the next `req_ready` comes 2 cycles after `uart_txBusy` falls (DRAIN→ACCEPT, then ACCEPT);
  - the wire gap between bytes is at most 3 clk cycles.
- **Handshake:**
  - A byte transfers in exactly the cycle where `req_valid` and `req_ready` are both high.
  - Requesters hold `req_data`/`req_last` stable while `req_valid` is high.
  - Requesters must not drop `req_valid` until `req_ready` is seen.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN`, when defined:
  - A stall counter counts consecutive ACCEPT cycles with `req_valid[grant_id]` low.
  - When the counter reaches `TIMEOUT_CYCLES`, the arbiter clears `grant_active`, pulses `timeout_event` for one cycle, and goes to IDLE.
  - The stall counter resets on every accept and on every entry into ACCEPT.
- `UART_TX_ARB_TIMEOUT_EN`, when undefined:
  - There is no counter; the lock is held indefinitely.
  - `timeout_event` is tied to 0.

## Test plan
- **Single byte:** reset, then requester 1 sends 8'h48 with `req_last`=1.
  - Expect `req_ready[1]` at cycle +2 and `uart_txEnable` at +3.
  - The bench FastUART receives "H".
  - `grant_active` falls after `txBusy` falls.
- **Packet lock:** requester 0 sends "Hello" (last on 'o'); requester 2 sends "AB" starting 1 cycle later.
  - The wire carries exactly "HelloAB".
  - `req_ready[2]` stays 0 until 'o' has drained.
- **Fairness:** all 4 requesters continuously send 1-byte packets, 0x30+i.
  - The output order is 0,1,2,3,0,1,… for at least 12 bytes.
- **Stall inside a packet:** the owner drops `req_valid` for 50 cycles after its first byte while requester 3 is waiting.
  - There is no grant change and no byte from requester 3 until the owner's last byte.
  - With `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `timeout_event` pulses after 16 cycles and requester 3 is granted next.
- **Reset mid-byte:** assert `rst_n`=0 during DRAIN.
  - `req_ready`, `uart_txEnable` and `grant_active` go to 0 within the same cycle.
  - After release, `grant_id` = `REQUESTERS`-1 and arbitration restarts at requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter sharing one FastUART
// transmitter between byte-stream requesters (valid/ready/last handshake).
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN (force-release of a stalled lock).
module uart_tx_arbiter #(
  parameter int unsigned  REQUESTERS     = 4,
  parameter int unsigned  TIMEOUT_CYCLES = 1024,
  localparam int unsigned GW             = $clog2(REQUESTERS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REQUESTERS-1:0]   req_valid,
  input  logic [8*REQUESTERS-1:0] req_data,
  input  logic [REQUESTERS-1:0]   req_last,
  output logic [REQUESTERS-1:0]   req_ready,
  output logic                    uart_txEnable,
  output logic [7:0]              uart_txData,
  input  logic                    uart_txBusy,
  output logic [GW-1:0]           grant_id,
  output logic                    grant_active,
  output logic                    timeout_event
);

  // Elaboration-time parameter range checks
  if (REQUESTERS < 2 || REQUESTERS > 8) begin : g_bad_req
    $error("uart_tx_arbiter: REQUESTERS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_ACCEPT, S_SEND, S_HOLD, S_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [GW-1:0]           gid_q, gid_d;
  logic                    active_q, active_d;
  logic [REQUESTERS-1:0]   ready_q, ready_d;
  logic                    en_q, en_d;
  logic [7:0]              data_q, data_d;
  logic                    last_q, last_d;
  logic [GW-1:0]           win_c;
  logic                    found_c;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]           stall_q, stall_d;
  logic                    timeout_q, timeout_d;
`endif

  // Round-robin search starting just after the last owner (grant_id doubles as rr_ptr)
  always_comb begin
    win_c   = gid_q;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= REQUESTERS; i++) begin
      logic [GW-1:0] cand;
      cand = GW'((32'(gid_q) + i) % REQUESTERS);
      if (!found_c && req_valid[cand]) begin
        found_c = 1'b1;
        win_c   = cand;
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    active_d = active_q;
    ready_d  = '0;
    en_d     = 1'b0;
    data_d   = data_q;
    last_d   = last_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
    stall_d   = '0;
    if (state_q == S_ACCEPT && !req_valid[gid_q]) stall_d = stall_q + CW'(1);
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid) state_d = S_ARB;
      end
      S_ARB: begin
        if (found_c) begin
          gid_d    = win_c;
          active_d = 1'b1;
          state_d  = S_ACCEPT;
          // Pre-arm the strobe so the first byte is accepted in the first ACCEPT cycle
          if (!uart_txBusy) ready_d[win_c] = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        if (ready_q[gid_q] && req_valid[gid_q]) begin
          data_d  = req_data[{gid_q, 3'b000} +: 8];
          last_d  = req_last[gid_q];
          en_d    = 1'b1;
          state_d = S_SEND;
        end else if (req_valid[gid_q] && !uart_txBusy) begin
          ready_d[gid_q] = 1'b1;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (!req_valid[gid_q] && stall_q == CW'(TIMEOUT_CYCLES - 1)) begin
          active_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
`endif
      end
      S_SEND: state_d = S_HOLD;
      S_HOLD: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!uart_txBusy) begin
          if (last_q) begin
            active_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_ACCEPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gid_q    <= GW'(REQUESTERS - 1);
      active_q <= 1'b0;
      ready_q  <= '0;
      en_q     <= 1'b0;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      en_q     <= en_d;
      data_q   <= data_d;
      last_q   <= last_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign req_ready     = ready_q;
  assign uart_txEnable = en_q;
  assign uart_txData   = data_q;
  assign grant_id      = gid_q;
  assign grant_active  = active_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_event = timeout_q;
`else
  assign timeout_event = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle table for the single-byte case,
// hand-written multi-cycle sequences, and randomized packets vs a round-robin model.
module tb_uart_tx_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned GW = 2;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [8*N-1:0]   req_data;
  logic             uart_txEnable, uart_txBusy, grant_active, timeout_event;
  logic [7:0]       uart_txData;
  logic [GW-1:0]    grant_id;
  logic             busy_tab, busy_model;

  assign uart_txBusy = busy_tab | busy_model;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.REQUESTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_txEnable(uart_txEnable),
    .uart_txData(uart_txData), .uart_txBusy(uart_txBusy), .grant_id(grant_id),
    .grant_active(grant_active), .timeout_event(timeout_event));

  typedef struct { logic [7:0] b; logic last; int gap; } item_t;
  typedef struct { logic v; logic b; logic [N-1:0] rdy; logic en; logic ga;
                   logic [GW-1:0] gid; logic [7:0] d; } vec_t;

  int          n_chk = 0, n_fail = 0;
  item_t       q [N][$];
  int          start_cyc [N];
  int          gap_cnt [N];
  logic [N-1:0] vld;
  logic [7:0]  wire_log [$];
  logic [7:0]  exp_q [$];
  int          busy_cnt, busy_len, cyc, to_cnt;
  logic        prev_busy;
  logic [7:0]  prev_data;
  vec_t        tbl [10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = vld[i];
      if (q[i].size() > 0) begin
        req_data[8*i +: 8] = q[i][0].b;
        req_last[i]        = q[i][0].last;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld = '0; req_valid = '0; req_data = '0; req_last = '0;
    busy_tab = 1'b0; busy_model = 1'b0; busy_cnt = 0; prev_busy = 1'b0;
    cyc = 0; to_cnt = 0;
    for (int i = 0; i < N; i++) begin
      q[i].delete(); gap_cnt[i] = 0; start_cyc[i] = 0;
    end
    wire_log.delete(); exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_item(int r, logic [7:0] b, logic last, int gap);
    item_t it;
    it.b = b; it.last = last; it.gap = gap;
    q[r].push_back(it);
  endtask

  task automatic add_str(int r, string s);
    for (int i = 0; i < s.len(); i++) add_item(r, s[i], (i == s.len() - 1), 0);
  endtask

  task automatic exp_str(string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Per-cycle protocol checks, taken at the falling edge
  task automatic protocol_checks();
    if (req_ready !== '0) begin
      chk("ready_owner", 32'(req_ready), grant_active ? (32'(1) << grant_id) : 32'(0));
      chk("ready_needs_valid", 32'(req_ready & ~req_valid), 32'(0));
    end
    if (uart_txEnable === 1'b1) chk("enable_while_busy", 32'(uart_txBusy), 32'(0));
    if (prev_busy && busy_model) chk("data_stable_busy", 32'(uart_txData), 32'(prev_data));
    prev_busy = busy_model;
    prev_data = uart_txData;
  endtask

  // One clock of requester models plus a FastUART model (busy starts the cycle after enable)
  task automatic run_cycle();
    logic [N-1:0] hs;
    logic         en_s;
    logic [7:0]   d_s;
    @(negedge clk);
    hs   = req_valid & req_ready;
    en_s = uart_txEnable;
    d_s  = uart_txData;
    protocol_checks();
    if (timeout_event === 1'b1) to_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (busy_cnt > 0) busy_cnt--;
    if (en_s) begin
      wire_log.push_back(d_s);
      busy_cnt = busy_len;
    end
    busy_model = (busy_cnt > 0);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        q[i].delete(0);
        vld[i] = 1'b0;
        if (q[i].size() > 0) gap_cnt[i] = q[i][0].gap;
      end
      if (!vld[i] && q[i].size() > 0 && cyc >= start_cyc[i]) begin
        if (gap_cnt[i] > 0) gap_cnt[i]--;
        else vld[i] = 1'b1;
      end
    end
    drive_reqs();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_seq(string name, int max_cyc);
    int idle;
    idle = 0;
    for (int k = 0; k < max_cyc && idle < 8; k++) begin
      run_cycle();
      if (all_empty() && vld == '0 && busy_cnt == 0 && grant_active === 1'b0) idle++;
      else idle = 0;
    end
    chk({name, "_completes"}, 32'(idle >= 8), 32'(1));
    chk({name, "_wire_len"}, 32'(wire_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i),
          (i < wire_log.size()) ? 32'(wire_log[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    wire_log.delete();
    exp_q.delete();
  endtask

  // Reference: whole packets, round-robin from the pointer after the last owner
  task automatic build_rr_expect();
    item_t qc [N][$];
    item_t it;
    int    ptr;
    bool_loop: begin end
    ptr = N - 1;
    for (int i = 0; i < N; i++) qc[i] = q[i];
    forever begin
      int pick;
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        int r;
        r = (ptr + k) % N;
        if (pick < 0 && qc[r].size() > 0) pick = r;
      end
      if (pick < 0) break;
      do begin
        it = qc[pick].pop_front();
        exp_q.push_back(it.b);
      end while (!it.last);
      ptr = pick;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    busy_len = 4;
    // Single byte 'H' from requester 1: {valid1, busy} in, {ready, en, active, id, data} out
    tbl[0] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h48};
    tbl[5] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h48};
    tbl[6] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h48};
    tbl[7] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h48};
    tbl[8] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h48};
    tbl[9] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h48};

    do_reset();
    req_data[15:8] = 8'h48;
    req_last[1]    = 1'b1;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r),  32'(req_ready),     32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_enable", r), 32'(uart_txEnable), 32'(tbl[r].en));
      chk($sformatf("tbl%0d_active", r), 32'(grant_active),  32'(tbl[r].ga));
      chk($sformatf("tbl%0d_id", r),     32'(grant_id),      32'(tbl[r].gid));
      chk($sformatf("tbl%0d_data", r),   32'(uart_txData),   32'(tbl[r].d));
      chk($sformatf("tbl%0d_timeout", r), 32'(timeout_event), 32'(0));
      req_valid    = '0;
      req_valid[1] = tbl[r].v;
      busy_tab     = tbl[r].b;
    end

    // Packet lock: "Hello" from 0, "AB" from 2 one cycle later
    do_reset();
    add_str(0, "Hello");
    add_str(2, "AB");
    start_cyc[2] = 2;
    exp_str("HelloAB");
    run_seq("lock", 2000);

    // Fairness: every requester streams one-byte packets 0x30+i
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) add_item(i, 8'(8'h30 + i), 1'b1, 0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) exp_q.push_back(8'(8'h30 + i));
    run_seq("fair", 2000);

    // Stall inside a packet while requester 3 waits
    do_reset();
    busy_len = 3;
    add_str(0, "XY");
    q[0][1].gap = 50;
    add_str(3, "Z");
    start_cyc[3] = 3;
`ifdef UART_TX_ARB_TIMEOUT_EN
    exp_str("XZY");
    run_seq("stall", 2000);
    chk("stall_timeout_pulses", 32'(to_cnt), 32'(1));
`else
    exp_str("XYZ");
    run_seq("stall", 2000);
    chk("stall_timeout_pulses", 32'(to_cnt), 32'(0));
`endif

    // Reset while the first byte of a packet drains
    do_reset();
    busy_len = 6;
    add_str(1, "QR");
    for (int k = 0; k < 50 && wire_log.size() == 0; k++) run_cycle();
    chk("rst_first_byte_sent", 32'(wire_log.size()), 32'(1));
    run_cycle();
    chk("rst_pre_active", 32'(grant_active), 32'(1));
    chk("rst_pre_id", 32'(grant_id), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", 32'(req_ready), 32'(0));
    chk("rst_async_enable", 32'(uart_txEnable), 32'(0));
    chk("rst_async_active", 32'(grant_active), 32'(0));
    chk("rst_async_id", 32'(grant_id), 32'(N - 1));
    q[1].delete();
    vld = '0;
    req_valid = '0;
    prev_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    add_str(0, "a");
    add_str(2, "b");
    exp_str("Qab");
    run_seq("rst_restart", 2000);

    // Randomized packets against the round-robin packet model
    for (int it = 0; it < 5; it++) begin
      do_reset();
      busy_len = $urandom_range(8, 1);
      for (int r = 0; r < N; r++) begin
        int npk;
        npk = $urandom_range(3, 0);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(4, 1);
          for (int j = 0; j < len; j++)
            add_item(r, 8'($urandom), (j == len - 1), (j == 0) ? 0 : $urandom_range(3, 0));
        end
      end
      build_rr_expect();
      run_seq($sformatf("rand%0d", it), 5000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
